// File: rtl/aes_regs_pkg.sv
// Shared constants for the AES Avalon register slave: FSM states, register addresses, DONE bits.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package aes_regs_pkg;

  // Handshake FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Word addresses of the register map
  localparam logic [3:0] ADDR_KEY0  = 4'd0;
  localparam logic [3:0] ADDR_ENC0  = 4'd4;
  localparam logic [3:0] ADDR_DEC0  = 4'd8;
  localparam logic [3:0] ADDR_START = 4'd14;
  localparam logic [3:0] ADDR_DONE  = 4'd15;

  // DONE register bit positions
  localparam int DONE_BIT_CMPL = 0;
  localparam int DONE_BIT_ERR  = 1;

  // Plaintext words and the DONE register are owned by the core side, not the bus.
  function automatic logic bus_writable(input logic [3:0] addr);
    return !(((addr >= ADDR_DEC0) && (addr <= (ADDR_DEC0 + 4'd3))) || (addr == ADDR_DONE));
  endfunction

endpackage

// File: rtl/aes_handshake_fsm.sv
// Start/done handshake with the AES core plus the RUN timeout counter.
// Latency: IDLE->RUN one edge after start_bit is seen; completion strobes are combinational in RUN.
// Backpressure: none; the core is waited on up to TIMEOUT_CYCLES, then an error completion fires.
module aes_handshake_fsm
  import aes_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_bit,
  input  logic       aes_done,
  output logic       aes_start,
  output logic       load_snapshot,
  output logic       capture_dec,
  output logic [1:0] set_done,
  output logic       clear_done
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout;

  // Last RUN cycle before the error completion is forced
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign aes_start = (state == ST_RUN);

  // Next state and the one-cycle strobes towards the register file
  always_comb begin
    state_nxt     = state;
    load_snapshot = 1'b0;
    capture_dec   = 1'b0;
    set_done      = 2'b00;
    clear_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_bit) begin
          load_snapshot = 1'b1;
          state_nxt     = ST_RUN;
        end
      end
      ST_RUN: begin
        // A completion from the core wins over a coincident timeout
        if (aes_done) begin
          capture_dec             = 1'b1;
          set_done[DONE_BIT_CMPL] = 1'b1;
          state_nxt               = ST_FIN;
        end else if (timeout) begin
          set_done[DONE_BIT_CMPL] = 1'b1;
          set_done[DONE_BIT_ERR]  = 1'b1;
          state_nxt               = ST_FIN;
        end
      end
      ST_FIN: begin
        // Software must drop START before another run can begin
        if (!start_bit) begin
          clear_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout counter: cleared on entry to RUN, counts every RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_snapshot) begin
      cnt <= '0;
    end else if (state == ST_RUN) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/avalon_aes_slave_regs.sv
// Avalon-MM register file between the Nios II master and the AES decrypt core, with hex export.
// Latency: reads return one cycle after the strobe; writes land at the next edge.
// Backpressure: none; the slave never stalls, fixed read latency 1 and no waitrequest.
module avalon_aes_slave_regs
  import aes_regs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic [3:0]   avs_address,
  input  logic         avs_chipselect,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [3:0]   avs_byteenable,
  input  logic [31:0]  avs_writedata,
  output logic [31:0]  avs_readdata,
  output logic [127:0] aes_key,
  output logic [127:0] aes_msg_enc,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_msg_dec,
  output logic [31:0]  export_data
);

  logic [31:0] regs [16];
  logic        load_snapshot;
  logic        capture_dec;
  logic [1:0]  set_done;
  logic        clear_done;

  aes_handshake_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_fsm (
    .clk           (clk_clk),
    .rst_n         (reset_reset_n),
    .start_bit     (regs[ADDR_START][0]),
    .aes_done      (aes_done),
    .aes_start     (aes_start),
    .load_snapshot (load_snapshot),
    .capture_dec   (capture_dec),
    .set_done      (set_done),
    .clear_done    (clear_done)
  );

  assign export_data = {regs[ADDR_KEY0][31:16], regs[ADDR_KEY0 + 4'd3][15:0]};

  // Register file: byte-masked bus writes, then core-side updates of plaintext and DONE
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (avs_chipselect && avs_write && bus_writable(avs_address)) begin
        for (int b = 0; b < 4; b++) begin
          if (avs_byteenable[b]) begin
            regs[avs_address][8*b +: 8] <= avs_writedata[8*b +: 8];
          end
        end
      end
      if (load_snapshot) begin
        for (int i = 0; i < 4; i++) begin
          regs[ADDR_DEC0 + 4'(i)] <= '0;
        end
      end
      // Most significant plaintext word lands in the lowest address
      if (capture_dec) begin
        for (int i = 0; i < 4; i++) begin
          regs[ADDR_DEC0 + 4'(i)] <= aes_msg_dec[127 - 32*i -: 32];
        end
      end
      if (set_done != 2'b00) begin
        regs[ADDR_DONE] <= {30'd0, set_done};
      end
      if (clear_done) begin
        regs[ADDR_DONE] <= '0;
      end
    end
  end

  // Read port: registered, holds the last value when not strobed
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_chipselect && avs_read) begin
      avs_readdata <= regs[avs_address];
    end
  end

  // Key and ciphertext are frozen at the start of a run so bus writes cannot disturb the core
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      aes_key     <= '0;
      aes_msg_enc <= '0;
    end else if (load_snapshot) begin
      aes_key     <= {regs[ADDR_KEY0], regs[ADDR_KEY0 + 4'd1],
                      regs[ADDR_KEY0 + 4'd2], regs[ADDR_KEY0 + 4'd3]};
      aes_msg_enc <= {regs[ADDR_ENC0], regs[ADDR_ENC0 + 4'd1],
                      regs[ADDR_ENC0 + 4'd2], regs[ADDR_ENC0 + 4'd3]};
    end
  end

endmodule

// File: tb/tb_avalon_aes_slave_regs.sv
// Bench for avalon_aes_slave_regs: directed scenarios plus random bus/core traffic against a model.
// Latency: model tracks read latency 1 and the START/RUN/DONE timing cycle by cycle.
// Backpressure: none; the DUT is driven every cycle without stalls.
module tb_avalon_aes_slave_regs;

  localparam int TO = 16;

  logic         clk_clk = 1'b0;
  logic         reset_reset_n;
  logic [3:0]   avs_address;
  logic         avs_chipselect;
  logic         avs_read;
  logic         avs_write;
  logic [3:0]   avs_byteenable;
  logic [31:0]  avs_writedata;
  logic [31:0]  avs_readdata;
  logic [127:0] aes_key;
  logic [127:0] aes_msg_enc;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_msg_dec;
  logic [31:0]  export_data;

  int checks = 0;
  int errors = 0;

  avalon_aes_slave_regs #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_byteenable (avs_byteenable),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .aes_key        (aes_key),
    .aes_msg_enc    (aes_msg_enc),
    .aes_start      (aes_start),
    .aes_done       (aes_done),
    .aes_msg_dec    (aes_msg_dec),
    .export_data    (export_data)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 waiting for START, 1 core running, 2 finished and waiting for START to drop.
  logic [31:0]  m_regs [16];
  logic [31:0]  m_rd;
  logic [127:0] m_key, m_enc;
  int           m_phase;
  int           m_run_cycles;

  always @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= 32'd0;
      m_rd <= 32'd0; m_key <= '0; m_enc <= '0; m_phase <= 0; m_run_cycles <= 0;
    end else begin
      if (avs_chipselect && avs_read) m_rd <= m_regs[avs_address];
      if (avs_chipselect && avs_write && (avs_address < 4'd8 || (avs_address >= 4'd12 && avs_address <= 4'd14)))
        for (int b = 0; b < 4; b++)
          if (avs_byteenable[b]) m_regs[avs_address][8*b +: 8] <= avs_writedata[8*b +: 8];
      if (m_phase == 0) begin
        if (m_regs[14][0]) begin
          m_phase <= 1; m_run_cycles <= 0;
          m_key <= {m_regs[0], m_regs[1], m_regs[2], m_regs[3]};
          m_enc <= {m_regs[4], m_regs[5], m_regs[6], m_regs[7]};
          for (int i = 8; i < 12; i++) m_regs[i] <= 32'd0;
        end
      end else if (m_phase == 1) begin
        m_run_cycles <= m_run_cycles + 1;
        if (aes_done) begin
          for (int i = 0; i < 4; i++) m_regs[8+i] <= aes_msg_dec[127-32*i -: 32];
          m_regs[15] <= 32'd1; m_phase <= 2;
        end else if (m_run_cycles + 1 == TO) begin
          m_regs[15] <= 32'd3; m_phase <= 2;
        end
      end else begin
        if (!m_regs[14][0]) begin
          m_regs[15] <= 32'd0; m_phase <= 0;
        end
      end
    end
  end

  // Every-cycle compare, away from the rising edge
  always @(negedge clk_clk) begin
    #2;
    chk("readdata", {96'd0, avs_readdata}, {96'd0, m_rd});
    chk("aes_start", {127'd0, aes_start}, {127'd0, (m_phase == 1)});
    chk("aes_key", aes_key, m_key);
    chk("aes_msg_enc", aes_msg_enc, m_enc);
    chk("export_data", {96'd0, export_data}, {96'd0, m_regs[0][31:16], m_regs[3][15:0]});
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d; avs_byteenable = be;
    @(negedge clk_clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    @(negedge clk_clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(negedge clk_clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    #3;
    chk(name, {96'd0, avs_readdata}, {96'd0, exp});
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset_n = 1'b0; avs_address = 4'd0; avs_chipselect = 1'b0; avs_read = 1'b0;
    avs_write = 1'b0; avs_byteenable = 4'd0; avs_writedata = 32'd0; aes_done = 1'b0;
    aes_msg_dec = '0;
    idle(3);
    reset_reset_n = 1'b1;

    // Reset state
    #2;
    chk("rst_start", {127'd0, aes_start}, 128'd0);
    chk("rst_export", {96'd0, export_data}, 128'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'd0, "rst_read");

    // Byte enables and read-only plaintext
    wr(4'd0, 32'hDEADBEEF, 4'b1111);
    wr(4'd3, 32'h12345678, 4'b0011);
    rd(4'd3, 32'h00005678, "be_r3");
    chk("be_export", {96'd0, export_data}, {96'd0, 32'hDEAD5678});
    wr(4'd9, 32'hFFFFFFFF, 4'b1111);
    rd(4'd9, 32'd0, "ro_r9");
    wr(4'd15, 32'hFFFFFFFF, 4'b1111);
    rd(4'd15, 32'd0, "ro_r15");

    // Normal decrypt
    wr(4'd1, 32'h11111111, 4'hF);
    wr(4'd2, 32'h22222222, 4'hF);
    for (int i = 4; i < 8; i++) wr(4'(i), {4{4'hA, 4'(i)}}, 4'hF);
    wr(4'd14, 32'h00000001, 4'hF);
    #2 chk("start_not_yet", {127'd0, aes_start}, 128'd0);
    @(negedge clk_clk); #2;
    chk("start_rise", {127'd0, aes_start}, 128'd1);
    chk("key_snap", aes_key, 128'hDEADBEEF_11111111_22222222_00005678);
    chk("enc_snap", aes_msg_enc, 128'hA4A4A4A4_A5A5A5A5_A6A6A6A6_A7A7A7A7);
    wr(4'd0, 32'd0, 4'hF);
    chk("key_frozen", aes_key, 128'hDEADBEEF_11111111_22222222_00005678);
    @(negedge clk_clk);
    aes_done = 1'b1; aes_msg_dec = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    @(negedge clk_clk);
    aes_done = 1'b0; aes_msg_dec = '0;
    #2 chk("start_fall", {127'd0, aes_start}, 128'd0);
    rd(4'd8, 32'h00112233, "dec_r8");
    rd(4'd11, 32'hCCDDEEFF, "dec_r11");
    rd(4'd15, 32'd1, "done_r15");
    wr(4'd14, 32'd0, 4'hF);
    idle(1);
    rd(4'd15, 32'd0, "done_clear");

    // Timeout
    wr(4'd14, 32'd1, 4'hF);
    idle(16);
    #2 chk("to_last_run", {127'd0, aes_start}, 128'd1);
    idle(1);
    #2 chk("to_start_off", {127'd0, aes_start}, 128'd0);
    rd(4'd15, 32'd3, "to_r15");
    for (int i = 8; i < 12; i++) rd(4'(i), 32'd0, "to_dec_zero");
    wr(4'd14, 32'd0, 4'hF);
    idle(2);

    // START cleared in the same cycle as aes_done
    wr(4'd14, 32'd1, 4'hF);
    idle(3);
    @(negedge clk_clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = 4'd14; avs_writedata = 32'd0;
    avs_byteenable = 4'hF; aes_done = 1'b1; aes_msg_dec = 128'hCAFEF00D_01234567_89ABCDEF_FEEDFACE;
    @(negedge clk_clk);
    avs_write = 1'b0; aes_done = 1'b0; aes_msg_dec = '0; avs_read = 1'b1; avs_address = 4'd15;
    @(negedge clk_clk);
    avs_read = 1'b0; avs_chipselect = 1'b0;
    #3 chk("race_done_pulse", {96'd0, avs_readdata}, {96'd0, 32'd1});
    rd(4'd15, 32'd0, "race_r15");
    rd(4'd8, 32'hCAFEF00D, "race_r8");
    rd(4'd11, 32'hFEEDFACE, "race_r11");

    // Asynchronous reset in the middle of a run
    wr(4'd14, 32'd1, 4'hF);
    idle(3);
    #2 chk("mid_run", {127'd0, aes_start}, 128'd1);
    @(negedge clk_clk); #1;
    reset_reset_n = 1'b0;
    #1 chk("async_drop", {127'd0, aes_start}, 128'd0);
    idle(2);
    reset_reset_n = 1'b1;
    for (int i = 0; i < 16; i++) rd(4'(i), 32'd0, "post_rst_read");
    idle(2);
    #2 chk("post_rst_idle", {127'd0, aes_start}, 128'd0);

    // Random traffic, biased towards the START register
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_clk);
      avs_chipselect = ($urandom_range(0, 3) != 0);
      avs_read       = $urandom_range(0, 1) == 1;
      avs_write      = $urandom_range(0, 2) == 0;
      avs_address    = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      avs_byteenable = 4'($urandom_range(0, 15));
      avs_writedata  = $urandom;
      aes_done       = ($urandom_range(0, 9) == 0);
      aes_msg_dec    = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk_clk);
    avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0; aes_done = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
